// File: rtl/gcd_wb_responder.sv
// gcd_wb_responder
//   Wishbone slave holding two 32-bit operands. A start command runs a
//   subtractive Euclid engine at one step per clock. The block exposes
//   RESULT, STATUS, the iteration count (CYCLES) and an optional level
//   interrupt.
//
//   Register map, relative to BASE_ADDR (byte offsets):
//     0x00 A       RW, byte enables honoured
//     0x04 B       RW, byte enables honoured
//     0x08 CTRL    bit0 start (write-1 pulse, reads 0), bit1 irq_en
//     0x0C STATUS  bit0 busy (RO), bit1 done (W1C), bit2 err (W1C)
//     0x10 RESULT  RO
//     0x14 CYCLES  RO, RUN cycles of the last operation
//
//   Ports:
//     wb_clk_i            clock
//     resetb              asynchronous active-low reset
//     wbs_cyc_i/stb_i/we_i, wbs_sel_i[3:0], wbs_adr_i[31:0], wbs_dat_i[31:0]
//                         Wishbone request
//     wbs_ack_o           single-cycle acknowledge, one cycle after sampling
//     wbs_dat_o[31:0]     registered read data, valid while ack is high
//     irq_o               done & irq_en
//
//   Build option: define GCD_IRQ_EN to implement CTRL.irq_en and irq_o.
//   Without it, CTRL bit1 reads 0 and irq_o is tied low.
module gcd_wb_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic [7:0] OFS_A      = 8'h00;
  localparam logic [7:0] OFS_B      = 8'h04;
  localparam logic [7:0] OFS_CTRL   = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_RESULT = 8'h10;
  localparam logic [7:0] OFS_CYCLES = 8'h14;

  logic        state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d;
  logic [31:0] res_q, res_d, cyc_q, cyc_d, rdat_q, rdat_d;
  logic        done_q, done_d, err_q, err_d, irqen_q, irqen_d, ack_q, ack_d;

  logic        hit, req, wr, busy, start, term;
  logic [7:0]  ofs;
  logic [31:0] cnt_inc, rd_mux;

  function automatic logic [31:0] bmerge(input logic [31:0] cur,
                                         input logic [31:0] wd,
                                         input logic [3:0]  sel);
    logic [31:0] r;
    r[7:0]   = sel[0] ? wd[7:0]   : cur[7:0];
    r[15:8]  = sel[1] ? wd[15:8]  : cur[15:8];
    r[23:16] = sel[2] ? wd[23:16] : cur[23:16];
    r[31:24] = sel[3] ? wd[31:24] : cur[31:24];
    return r;
  endfunction

  assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A request is sampled only while ack is low, giving two cycles per transfer.
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign wr      = req & wbs_we_i;
  assign ofs     = wbs_adr_i[7:0];
  assign busy    = (state_q == S_RUN);
  assign start   = wr && (ofs == OFS_CTRL) && wbs_sel_i[0] && wbs_dat_i[0] && !busy;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
  assign term    = busy && ((x_q == '0) || (y_q == '0) || (x_q == y_q));

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_A:      rd_mux = a_q;
      OFS_B:      rd_mux = b_q;
      OFS_CTRL:   rd_mux = {30'd0, irqen_q, 1'b0};
      OFS_STATUS: rd_mux = {29'd0, err_q, done_q, busy};
      OFS_RESULT: rd_mux = res_q;
      OFS_CYCLES: rd_mux = cyc_q;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    err_d   = err_q;
    irqen_d = irqen_q;
    ack_d   = req;
    rdat_d  = req ? rd_mux : rdat_q;

    if (wr) begin
      case (ofs)
        OFS_A: a_d = bmerge(a_q, wbs_dat_i, wbs_sel_i);
        OFS_B: b_d = bmerge(b_q, wbs_dat_i, wbs_sel_i);
`ifdef GCD_IRQ_EN
        OFS_CTRL: if (wbs_sel_i[0]) irqen_d = wbs_dat_i[1];
`endif
        OFS_STATUS: begin
          if (wbs_sel_i[0] && wbs_dat_i[1]) done_d = 1'b0;
          if (wbs_sel_i[0] && wbs_dat_i[2]) err_d  = 1'b0;
        end
        default: ;
      endcase
    end

    if (start) begin
      x_d     = a_q;
      y_d     = b_q;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      state_d = S_RUN;
    end

    // Evaluated after the W1C decode so a terminating step wins a same-edge clear.
    if (busy) begin
      cnt_d = cnt_inc;
      if (term) begin
        res_d   = (x_q == '0) ? y_q : x_q;
        if ((x_q == '0) && (y_q == '0)) err_d = 1'b1;
        cyc_d   = cnt_inc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (x_q > y_q) begin
        x_d = x_q - y_q;
      end else begin
        y_d = y_q - x_q;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irqen_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irqen_q <= irqen_d;
      ack_q   <= ack_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
`ifdef GCD_IRQ_EN
  assign irq_o = done_q & irqen_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_wb_responder.sv
module tb_gcd_wb_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef GCD_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack, irq;
  logic [31:0] rdat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_wb_responder #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .resetb   (resetb),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_o    (irq)
  );

  // Behavioural model: register file plus one pending operation whose
  // outcome is computed up front and committed when its end edge passes.
  logic [31:0] m_a, m_b, m_res, m_cyc;
  bit          m_done, m_err, m_irqen;
  bit          op_active;
  longint      op_end;
  logic [31:0] op_res, op_n;
  bit          op_err;

  longint      edge_cnt = 0;
  longint      exp_ack_edge = -1;
  bit          exp_is_rd;
  logic [31:0] exp_rd;
  string       exp_name;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // GCD by repeated subtraction; n counts the steps including the final one.
  function automatic void gcd_ref(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] n,
                                  output bit e);
    logic [31:0] x, y;
    x = a; y = b; n = 0; r = 0; e = 0;
    while (1) begin
      n++;
      if (x == 0) begin r = y; e = (y == 0); return; end
      if (y == 0 || x == y) begin r = x; return; end
      if (x > y) x = x - y; else y = y - x;
    end
  endfunction

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_cyc = 0;
    m_done = 0; m_err = 0; m_irqen = 0;
    op_active = 0; exp_ack_edge = -1;
  endfunction

  function automatic void settle(input longint e);
    if (op_active && e >= op_end) begin
      m_res = op_res; m_cyc = op_n; m_done = 1;
      if (op_err) m_err = 1;
      op_active = 0;
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] c, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] ofs);
    case (ofs)
      8'h00: return m_a;
      8'h04: return m_b;
      8'h08: return {30'd0, m_irqen, 1'b0};
      8'h0C: return {29'd0, m_err, m_done, op_active};
      8'h10: return m_res;
      8'h14: return m_cyc;
      default: return 32'd0;
    endcase
  endfunction

  // Write effects for the edge j that samples the request.
  function automatic void model_write(input logic [7:0] ofs, input logic [31:0] d,
                                      input logic [3:0] s, input longint j);
    case (ofs)
      8'h00: m_a = merge(m_a, d, s);
      8'h04: m_b = merge(m_b, d, s);
      8'h08: if (s[0]) begin
        if (IRQ_IMPL) m_irqen = d[1];
        if (d[0] && !op_active) begin
          gcd_ref(m_a, m_b, op_res, op_n, op_err);
          op_active = 1; op_end = j + op_n;
          m_done = 0; m_err = 0;
        end
      end
      8'h0C: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      default: ;
    endcase
  endfunction

  // Compare process: every cycle, #1 after the active edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      edge_cnt++;
      if (!resetb) begin
        model_reset();
        check("ack_in_reset", {31'd0, ack}, 32'd0);
        check("irq_in_reset", {31'd0, irq}, 32'd0);
      end else begin
        settle(edge_cnt);
        if (edge_cnt == exp_ack_edge) begin
          check("ack", {31'd0, ack}, 32'd1);
          if (exp_is_rd) check(exp_name, rdat, exp_rd);
        end else begin
          check("ack_idle", {31'd0, ack}, 32'd0);
        end
        check("irq", {31'd0, irq}, {31'd0, m_done & m_irqen});
      end
    end
  end

  task automatic bus(input bit w, input logic [7:0] ofs, input logic [31:0] d,
                     input logic [3:0] s = 4'hF, input bit decode = 1'b1,
                     input bit has_lit = 1'b0, input logic [31:0] lit = 32'd0);
    longint j;
    @(negedge clk);
    j = edge_cnt + 1;
    adr = (decode ? BASE : 32'h4000_0000) | {24'd0, ofs};
    dat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    if (decode) begin
      exp_ack_edge = j;
      exp_is_rd = !w;
      if (!w) begin
        exp_rd = model_read(ofs);
        exp_name = $sformatf("rd_%02h", ofs);
        if (has_lit) check($sformatf("model_%02h", ofs), exp_rd, lit);
      end else begin
        model_write(ofs, d, s, j);
      end
      @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_lit(input logic [7:0] ofs, input logic [31:0] lit);
    bus(1'b0, ofs, 32'd0, 4'hF, 1'b1, 1'b1, lit);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && op_active; i++) @(negedge clk);
    check("wait_done", {31'd0, op_active}, 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl = 32'h1);
    bus(1'b1, 8'h00, a);
    bus(1'b1, 8'h04, b);
    bus(1'b1, 8'h08, ctrl);
  endtask

  initial begin
    logic [7:0] ofs;
    model_reset();
    repeat (3) @(negedge clk);
    resetb = 1'b1;

    for (int i = 0; i <= 5; i++) begin
      ofs = 8'(4 * i);
      rd_lit(ofs, 32'd0);
    end

    // (48,18): busy through the run, then done with RESULT 6 in 5 cycles.
    run(32'd48, 32'd18);
    rd_lit(8'h0C, 32'h1);
    rd_lit(8'h0C, 32'h1);
    rd_lit(8'h0C, 32'h2);
    rd_lit(8'h10, 32'd6);
    rd_lit(8'h14, 32'd5);

    bus(1'b1, 8'h0C, 32'h2);
    rd_lit(8'h0C, 32'h0);

    run(32'd1, 32'd5);   wait_done();
    rd_lit(8'h10, 32'd1);  rd_lit(8'h14, 32'd5);

    run(32'd0, 32'd35);  wait_done();
    rd_lit(8'h10, 32'd35); rd_lit(8'h14, 32'd1); rd_lit(8'h0C, 32'h2);

    run(32'd0, 32'd0);   wait_done();
    rd_lit(8'h10, 32'd0);  rd_lit(8'h0C, 32'h6);
    bus(1'b1, 8'h0C, 32'h6);
    rd_lit(8'h0C, 32'h0);

    // Operand write and restart while running do not disturb the engine.
    run(32'd48, 32'd18);
    bus(1'b1, 8'h00, 32'd9);
    bus(1'b1, 8'h08, 32'h1);
    wait_done();
    rd_lit(8'h10, 32'd6);  rd_lit(8'h00, 32'd9);
    bus(1'b1, 8'h04, 32'd3);
    bus(1'b1, 8'h08, 32'h1); wait_done();
    rd_lit(8'h10, 32'd3);  rd_lit(8'h14, 32'd3);

    // Interrupt enable, completion, then W1C.
    bus(1'b1, 8'h08, 32'h2);
    rd_lit(8'h08, IRQ_IMPL ? 32'h2 : 32'h0);
    run(32'd12, 32'd8, 32'h3); wait_done();
    rd_lit(8'h10, 32'd4);  rd_lit(8'h14, 32'd3);
    repeat (2) @(negedge clk);
    bus(1'b1, 8'h0C, 32'h2);
    rd_lit(8'h0C, 32'h0);

    // Undecoded accesses: no ack, no side effect.
    bus(1'b1, 8'h00, 32'hDEAD_BEEF, 4'hF, 1'b0);
    bus(1'b0, 8'h10, 32'd0, 4'hF, 1'b0);
    rd_lit(8'h00, 32'd12);
    rd_lit(8'h18, 32'd0);

    // Reset mid-run.
    run(32'd48, 32'd18, 32'h1);
    @(negedge clk);
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    rd_lit(8'h0C, 32'h0);
    rd_lit(8'h10, 32'd0);
    run(32'd7, 32'd21); wait_done();
    rd_lit(8'h10, 32'd7);  rd_lit(8'h14, 32'd3);

    // Randomised traffic against the model.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0: bus(1'b1, 8'h00, ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 200), 4'($urandom_range(0, 15)));
        1: bus(1'b1, 8'h04, ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 200), 4'($urandom_range(0, 15)));
        2: bus(1'b1, 8'h08, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
        3: bus(1'b1, 8'h0C, 32'($urandom_range(0, 7)));
        4: bus(1'b0, 8'(4 * $urandom_range(0, 7)), 32'd0);
        5: bus(1'b0, 8'($urandom_range(0, 255)), 32'd0);
        6: bus($urandom_range(0, 1) == 1, 8'(4 * $urandom_range(0, 5)), $urandom, 4'hF, 1'b0);
        default: repeat ($urandom_range(1, 20)) @(negedge clk);
      endcase
    end
    wait_done();
    for (int i = 0; i <= 5; i++) begin
      ofs = 8'(4 * i);
      bus(1'b0, ofs, 32'd0);
    end
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_wb_responder.md
# gcd_wb_responder

Wishbone responder for the user project area: the slave end of the management-core bus that firmware drives to run GCD computations. Holds two 32-bit operands, runs a one-step-per-cycle subtractive Euclid engine on a start command, and exposes result, status, iteration count and an optional completion interrupt. Sits in the user project wrapper on the `wbs_*` bus alongside the GPIO signature logic driven by firmware.

## Interface

- `BASE_ADDR`, 32'h3000_0000, block base; decode on `wbs_adr_i[31:8] == BASE_ADDR[31:8]`
- `wb_clk_i`  input  1  sole clock
- `resetb`  input  1  asynchronous, active-low reset
- `wbs_cyc_i`  input  1  bus cycle valid
- `wbs_stb_i`  input  1  strobe
- `wbs_we_i`  input  1  1 = write
- `wbs_sel_i`  input  4  byte enables
- `wbs_adr_i`  input  32  byte address
- `wbs_dat_i`  input  32  write data
- `wbs_ack_o`  output  1  transfer acknowledge
- `wbs_dat_o`  output  32  read data
- `irq_o`  output  1  level interrupt, done & irq_en

Reset is asynchronous and active-low; one clock. All outputs and registers are 0 in reset.

## Operation

- Register map, offset `adr[7:0]`:
  - 0x00 A: RW, byte-enable honoured.
  - 0x04 B: RW, byte-enable honoured.
  - 0x08 CTRL:
    - bit0 start: write-1 pulse, reads 0.
    - bit1 irq_en: RW.
  - 0x0C STATUS:
    - bit0 busy: RO.
    - bit1 done: sticky, write-1-clear.
    - bit2 err: sticky, write-1-clear; set when A=B=0.
  - 0x10 RESULT: RO.
  - 0x14 CYCLES: RO; number of RUN cycles of the last operation.
  - Other offsets: read 0, writes ignored, still acked.
- FSM `IDLE` / `RUN`; working regs `x`, `y`, `cnt`.
- Start in IDLE:
  - `x<=A`, `y<=B`, `cnt<=0`.
  - Clear done and err.
  - Go to RUN.
- Start while RUN is ignored.
- RUN, each cycle:
  - `cnt<=cnt+1`.
  - If `x==0`: RESULT=y; err=1 if y==0. Terminate.
  - Else if `y==0` or `x==y`: RESULT=x. Terminate.
  - Else if `x>y`: `x<=x-y`.
  - Else: `y<=y-x`.
- Terminate: CYCLES=cnt+1, done=1, go to IDLE.
- Same-edge collision: a W1C of done on the edge that sets done loses. done stays 1.
- A/B writes during RUN update the registers only and do not affect the running computation.
- `cnt` is 32-bit and saturates at all-ones.

## Timing

- A request is sampled on the edge where `cyc&stb&!ack` is true and the address decodes.
  - Write takes effect at that edge.
  - `wbs_ack_o` is high for exactly the following cycle.
  - Read data is registered at that edge and valid while ack is high.
- A back-to-back request is sampled no earlier than the edge after ack drops. Minimum 2 cycles per transfer.
- Undecoded addresses: never acked, no side effects.
- Start write at edge k: busy reads 1 from k. The first RUN step is at edge k+1.
- Terminating step at edge k+n, where n = CYCLES:
  - busy=0 and done=1 from k+n.
  - `irq_o` rises at k+n if irq_en.
- Subtraction and comparison are unsigned 32-bit, with no wrap because the larger minus the smaller is always taken.
- `resetb` low at any time, including mid-RUN, clears everything asynchronously.
  - The FSM returns to IDLE.
  - An in-flight bus request is not acked.

## Configuration

- `GCD_IRQ_EN` defined: CTRL.irq_en is implemented and `irq_o` = done & irq_en.
- `GCD_IRQ_EN` undefined:
  - CTRL bit1 reads 0 and its write is ignored.
  - `irq_o` is tied 0.
  - All other behaviour is identical.

## Test plan

- Reset: hold `resetb`=0 → ack=0, irq=0. After release, reads of 0x00–0x14 all return 0.
- A=48, B=18, start → busy 1 for 5 cycles. Then RESULT=6, CYCLES=5, STATUS=0x2.
- A=1, B=5 → RESULT=1, CYCLES=5.
- A=0, B=35 → RESULT=35, CYCLES=1, err=0.
- A=0, B=0 → RESULT=0, STATUS=0x6.
- Start mid-run of (48,18) with A=9, B=3 already written → ignored; RESULT=6.
- Write 0x2 to STATUS → done clears.
- With `GCD_IRQ_EN`: irq_en=1, run (12,8) → `irq_o` rises with done; W1C drops it the cycle after ack.
- Reset mid-run: assert `resetb` 2 cycles after start of (48,18) → busy=0, RESULT=0. Afterwards, a new start of (7,21) gives RESULT=7, CYCLES=3.
